// File: rtl/tmip_act_sched.sv
// tmip_act_sched: collects a sequence of image actions, issues them one by one
// to the image engine, then serialises cross-correlation results MSB first.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high. cmd_valid/cmd_op/cmd_size hold steady until cmd_ready; res_ready is only
// offered when the shift register can take a new result, and res_data is
// captured on the same edge as the res_valid/res_ready transfer.
module tmip_act_sched #(
    parameter int QDEPTH = 8,
    parameter int RES_W  = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid2,
    input  logic [2:0]       action,
    input  logic [1:0]       img_size,
    output logic             cmd_valid,
    output logic [2:0]       cmd_op,
    output logic [1:0]       cmd_size,
    input  logic             cmd_ready,
    input  logic             eng_done,
    input  logic             res_valid,
    input  logic [RES_W-1:0] res_data,
    output logic             res_ready,
    output logic             out_valid,
    output logic             out_value,
    output logic [2:0]       dbg_state
);

    localparam int PW = $clog2(QDEPTH + 1);
    localparam int IW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int BW = $clog2(RES_W + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        CORR  = 3'd4,
        SHIFT = 3'd5
    } state_t;

    state_t            state, state_nx;
    logic [2:0]        queue [QDEPTH];
    logic [PW-1:0]     wp, rp;
    logic [1:0]        cur_size;
    logic [8:0]        res_cnt;
    logic [8:0]        res_total;
    logic [RES_W-1:0]  shreg;
    logic [BW-1:0]     bit_cnt;
    logic              q_empty;
    logic [2:0]        cur_op;
    logic              skip_pool;
    logic              res_hs;

    assign dbg_state = state;
    assign q_empty   = (rp >= wp);
    assign cur_op    = q_empty ? 3'd0 : queue[rp[IW-1:0]];
    // Max-pool on a 4x4 image cannot shrink further, so it is dropped.
    assign skip_pool = (cur_op == 3'd3) && (cur_size == 2'd0);
    assign res_hs    = res_valid && res_ready;

    // Number of correlation results equals the pixel count of the current image.
    always_comb begin
        res_total = 9'd256;
        case (cur_size)
            2'd0:    res_total = 9'd16;
            2'd1:    res_total = 9'd64;
            default: res_total = 9'd256;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nx  = state;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_size  = 2'd0;
        res_ready = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: if (in_valid2) state_nx = LOAD;
            LOAD: if (!in_valid2) state_nx = ISSUE;
            ISSUE: begin
                if (q_empty) begin
                    state_nx = IDLE;
                end else if (!skip_pool) begin
                    cmd_valid = 1'b1;
                    cmd_op    = cur_op;
                    cmd_size  = cur_size;
                    if (cmd_ready) state_nx = (cur_op == 3'd7) ? CORR : WAIT;
                end
            end
            WAIT: if (eng_done) state_nx = ISSUE;
            CORR: begin
                res_ready = (res_cnt != 9'd0);
                if (res_cnt == 9'd0)  state_nx = IDLE;
                else if (res_valid)   state_nx = SHIFT;
            end
            SHIFT: begin
                out_valid = 1'b1;
                // Offer the next result while the last bit leaves, so streams chain without a gap.
                res_ready = (bit_cnt == BW'(1)) && (res_cnt != 9'd0);
                if ((bit_cnt == BW'(1)) && !(res_valid && res_ready))
                    state_nx = (res_cnt == 9'd0) ? IDLE : CORR;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign out_value = out_valid & shreg[RES_W-1];

    // Action queue storage; only pointers need a reset value.
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid2)
            queue[0] <= action;
        else if (state == LOAD && in_valid2 && wp < PW'(QDEPTH))
            queue[wp[IW-1:0]] <= action;
    end

    // Pointers, current size, result counter and output shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp       <= '0;
            rp       <= '0;
            cur_size <= 2'd0;
            res_cnt  <= 9'd0;
            shreg    <= '0;
            bit_cnt  <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid2) begin
                    wp       <= PW'(1);
                    rp       <= '0;
                    cur_size <= img_size;
                end
                LOAD: begin
                    if (in_valid2 && wp < PW'(QDEPTH)) wp <= wp + PW'(1);
                    if (!in_valid2) rp <= '0;
                end
                ISSUE: if (!q_empty) begin
                    if (skip_pool)
                        rp <= rp + PW'(1);
                    else if (cmd_ready && cur_op == 3'd7)
                        res_cnt <= res_total;
                end
                WAIT: if (eng_done) begin
                    rp <= rp + PW'(1);
                    if (cur_op == 3'd3) cur_size <= cur_size - 2'd1;
                end
                default: ;
            endcase
            if (state == SHIFT) begin
                shreg   <= shreg << 1;
                bit_cnt <= bit_cnt - BW'(1);
            end
            if (res_hs) begin
                shreg   <= res_data;
                bit_cnt <= BW'(RES_W);
                res_cnt <= res_cnt - 9'd1;
            end
        end
    end

endmodule

// File: tb/tb_tmip_act_sched.sv
// Testbench for tmip_act_sched: directed scenarios with an engine responder,
// a result feeder and scoreboards for issued commands and serial output bits.
module tb_tmip_act_sched;

  localparam int RES_W = 20;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             in_valid2 = 1'b0;
  logic [2:0]       action = 3'd0;
  logic [1:0]       img_size = 2'd0;
  logic             cmd_ready = 1'b0;
  logic             eng_done = 1'b0;
  logic             res_valid = 1'b0;
  logic [RES_W-1:0] res_data = '0;
  logic             cmd_valid, res_ready, out_valid, out_value;
  logic [2:0]       cmd_op, dbg_state;
  logic [1:0]       cmd_size;

  tmip_act_sched #(.QDEPTH(8), .RES_W(RES_W)) dut (
    .clk(clk), .rst(rst), .in_valid2(in_valid2), .action(action), .img_size(img_size),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_size(cmd_size), .cmd_ready(cmd_ready),
    .eng_done(eng_done), .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .out_valid(out_valid), .out_value(out_value), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int tests_run = 0;
  int tests_failed = 0;
  logic [4:0] cmd_q[$];   // expected {op, size}
  logic [0:0] bit_q[$];   // expected serial bits
  logic [2:0] seq[16];
  int res_idx = 0, res_total = 0, gap_at = -1, gap_left = 0, eng_timer = 0;
  int stall_cnt = 0, gap_cnt = 0, bits_seen = 0;
  bit seen = 1'b0;
  bit prev_stall = 1'b0;
  logic [4:0] prev_cmd = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- monitor + responders (sample on negedge) ----------------
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("cmd_valid_held", {31'd0, cmd_valid}, 32'd1);
        chk("cmd_stable", {27'd0, cmd_op, cmd_size}, {27'd0, prev_cmd});
      end
      if (cmd_valid && cmd_ready) begin
        if (cmd_q.size() == 0) chk("cmd_unexpected", 32'd1, 32'd0);
        else chk("cmd", {27'd0, cmd_op, cmd_size}, {27'd0, cmd_q.pop_front()});
        if (cmd_op != 3'd7) eng_timer = 3;
      end else if (cmd_valid) begin
        stall_cnt++;
      end
      prev_stall = cmd_valid && !cmd_ready;
      prev_cmd = {cmd_op, cmd_size};

      if (out_valid) begin
        if (bit_q.size() == 0) chk("bit_unexpected", 32'd1, 32'd0);
        else chk("bit", {31'd0, out_value}, {31'd0, bit_q.pop_front()});
        bits_seen++;
        seen = 1'b1;
      end else begin
        chk("out_value_idle", {31'd0, out_value}, 32'd0);
        if (seen && bit_q.size() > 0) gap_cnt++;
      end

      if (res_valid && res_ready) res_idx++;
      else if (!res_valid && res_ready && res_idx == gap_at && gap_left > 0) gap_left--;
    end
  end

  // Engine done pulse and result feeder, driven just after the rising edge.
  always @(posedge clk) begin
    #1;
    eng_done = (eng_timer == 1);
    if (eng_timer > 0) eng_timer--;
    res_valid = (res_idx < res_total) && !(res_idx == gap_at && gap_left > 0);
    res_data = RES_W'(res_idx);
  end

  // ---------------- driver tasks ----------------
  task automatic start_results(input int n);
    logic [RES_W-1:0] v;
    res_idx = 0;
    res_total = n;
    seen = 1'b0;
    gap_cnt = 0;
    bits_seen = 0;
    for (int i = 0; i < n; i++) begin
      v = RES_W'(i);
      for (int b = RES_W - 1; b >= 0; b--) bit_q.push_back(v[b]);
    end
  endtask

  // Image size is only valid on the first cycle; later cycles carry junk.
  task automatic send(input logic [1:0] sz, input int n);
    @(posedge clk) #1;
    for (int i = 0; i < n; i++) begin
      in_valid2 = 1'b1;
      img_size = (i == 0) ? sz : 2'd3;
      action = seq[i];
      @(posedge clk) #1;
    end
    in_valid2 = 1'b0;
    action = 3'd0;
    img_size = 2'd0;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while ((cmd_q.size() != 0 || bit_q.size() != 0) && k < 20000) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_timeout"}, {31'd0, (k >= 20000)}, 32'd0);
    repeat (8) @(negedge clk);
    chk({tag, "_idle_state"}, {29'd0, dbg_state}, 32'd0);
    chk({tag, "_idle_out"}, {30'd0, out_valid, cmd_valid}, 32'd0);
  endtask

  task automatic wait_bits(input int n);
    int k;
    k = 0;
    while (bits_seen < n && k < 10000) begin
      @(negedge clk);
      k++;
    end
    chk("wait_bits_timeout", {31'd0, (k >= 10000)}, 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state", {29'd0, dbg_state}, 32'd0);
    chk("rst_outs", {26'd0, cmd_valid, res_ready, out_valid, out_value, cmd_op != 3'd0, cmd_size != 2'd0}, 32'd0);
    @(posedge clk) #1;
    rst = 1'b0;
    cmd_ready = 1'b1;

    // Size 8x8, grayscale then correlation: 64 contiguous results; stray in_valid2 while shifting.
    seq[0] = 3'd0; seq[1] = 3'd7;
    cmd_q.push_back({3'd0, 2'd1});
    cmd_q.push_back({3'd7, 2'd1});
    start_results(64);
    send(2'd1, 2);
    wait_bits(30);
    @(posedge clk) #1;
    in_valid2 = 1'b1; action = 3'd7; img_size = 2'd2;
    @(posedge clk) #1;
    in_valid2 = 1'b0; action = 3'd0; img_size = 2'd0;
    wait_idle("s1");
    chk("s1_gap", gap_cnt, 32'd0);
    chk("s1_bits", bits_seen, 64 * RES_W);

    // Size 16x16, pools shrink the image; third pool on 4x4 is skipped.
    seq[0] = 3'd1; seq[1] = 3'd3; seq[2] = 3'd3; seq[3] = 3'd3; seq[4] = 3'd7;
    cmd_q.push_back({3'd1, 2'd2});
    cmd_q.push_back({3'd3, 2'd2});
    cmd_q.push_back({3'd3, 2'd1});
    cmd_q.push_back({3'd7, 2'd0});
    start_results(16);
    send(2'd2, 5);
    wait_idle("s2");
    chk("s2_bits", bits_seen, 16 * RES_W);

    // Engine back-pressure: command held for 5 cycles, accepted once.
    cmd_ready = 1'b0;
    stall_cnt = 0;
    seq[0] = 3'd5; seq[1] = 3'd7;
    cmd_q.push_back({3'd5, 2'd0});
    cmd_q.push_back({3'd7, 2'd0});
    start_results(16);
    send(2'd0, 2);
    begin
      int k;
      k = 0;
      while (!cmd_valid && k < 100) begin
        @(negedge clk);
        k++;
      end
      chk("s3_cmd_seen", {31'd0, cmd_valid}, 32'd1);
    end
    repeat (4) @(negedge clk);
    @(posedge clk) #1;
    cmd_ready = 1'b1;
    wait_idle("s3");
    chk("s3_stalls", stall_cnt, 32'd5);

    // Result source stalls 3 cycles before result 3.
    seq[0] = 3'd7;
    cmd_q.push_back({3'd7, 2'd0});
    gap_at = 3;
    gap_left = 3;
    start_results(16);
    send(2'd0, 1);
    wait_idle("s4");
    chk("s4_gap", gap_cnt, 32'd3);
    chk("s4_bits", bits_seen, 16 * RES_W);
    gap_at = -1;

    // Ten actions offered; only the first eight stored, so the trailing op 7s never issue.
    seq[0] = 3'd0; seq[1] = 3'd1; seq[2] = 3'd2; seq[3] = 3'd4; seq[4] = 3'd5;
    seq[5] = 3'd6; seq[6] = 3'd0; seq[7] = 3'd1; seq[8] = 3'd7; seq[9] = 3'd7;
    for (int i = 0; i < 8; i++) cmd_q.push_back({seq[i], 2'd1});
    start_results(0);
    send(2'd1, 10);
    wait_idle("s5");
    chk("s5_bits", bits_seen, 32'd0);

    // Reset while result 5 is shifting, then a fresh sequence.
    seq[0] = 3'd7;
    cmd_q.push_back({3'd7, 2'd0});
    start_results(16);
    send(2'd0, 1);
    wait_bits(5 * RES_W + 3);
    @(posedge clk) #1;
    rst = 1'b1;
    res_total = 0;
    eng_timer = 0;
    @(posedge clk) #1;
    rst = 1'b0;
    bit_q.delete();
    cmd_q.delete();
    @(negedge clk);
    chk("s6_rst_state", {29'd0, dbg_state}, 32'd0);
    chk("s6_rst_outs", {26'd0, cmd_valid, res_ready, out_valid, out_value, cmd_op != 3'd0, cmd_size != 2'd0}, 32'd0);
    repeat (5) @(negedge clk);
    seq[0] = 3'd4; seq[1] = 3'd3; seq[2] = 3'd7;
    cmd_q.push_back({3'd4, 2'd0});
    cmd_q.push_back({3'd7, 2'd0});
    start_results(16);
    send(2'd0, 3);
    wait_idle("s6");
    chk("s6_bits", bits_seen, 16 * RES_W);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/tmip_act_sched.md
TMIP_ACT_SCHED -- requirements
Module: tmip_act_sched

Interface
REQ-001 SHALL have parameter QDEPTH, default 8, max actions stored per sequence.
REQ-002 SHALL have parameter RES_W, default 20, bit width of one cross-correlation result.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid2  input  1  high while an action sequence is presented, one action per cycle.
REQ-006 SHALL have port action  input  3  action code: 0-2 grayscale max/avg/weighted, 3 max-pool, 4 negative, 5 h-flip, 6 median filter, 7 cross-correlation.
REQ-007 SHALL have port img_size  input  2  size of the stored image (0:4x4, 1:8x8, 2:16x16); sampled on the first in_valid2 cycle.
REQ-008 SHALL have port cmd_valid  output  1  command to image engine valid.
REQ-009 SHALL have port cmd_op  output  3  action code issued.
REQ-010 SHALL have port cmd_size  output  2  current image size for the issued command.
REQ-011 SHALL have port cmd_ready  input  1  engine accepts command when cmd_valid and cmd_ready are both high.
REQ-012 SHALL have port eng_done  input  1  one-cycle pulse; the accepted non-correlation command has completed.
REQ-013 SHALL have port res_valid  input  1  cross-correlation result available.
REQ-014 SHALL have port res_data  input  RES_W  cross-correlation result, unsigned.
REQ-015 SHALL have port res_ready  output  1  result consumed when res_valid and res_ready are both high.
REQ-016 SHALL have port out_valid  output  1  serial output bit valid.
REQ-017 SHALL have port out_value  output  1  serial result bit, MSB first.

Function
REQ-018 SHALL implement FSM states IDLE, LOAD, ISSUE, WAIT, CORR, SHIFT.
REQ-019 IDLE: on in_valid2=1, SHALL store action into queue slot 0, latch img_size as cur_size, and go to LOAD.
REQ-020 LOAD: SHALL store one action per in_valid2=1 cycle; actions beyond QDEPTH SHALL be discarded; on in_valid2=0, SHALL go to ISSUE with read pointer 0.
REQ-021 ISSUE: SHALL drive cmd_valid=1, cmd_op=queue[rp], and cmd_size=cur_size; these SHALL hold stable until the handshake completes.
REQ-022 An action 3 with cur_size=0 SHALL NOT be issued; it SHALL be skipped in one cycle (rp+1), with cmd_valid staying 0 that cycle.
REQ-023 On handshake of op 0-6, SHALL go to WAIT; on eng_done, SHALL advance rp, and if op was 3 SHALL decrement cur_size by 1, then return to ISSUE.
REQ-024 On handshake of op 7, SHALL go to CORR with res_cnt = N*N (N = 4/8/16 per cur_size); queue entries after the first 7 SHALL be ignored.
REQ-025 If the queue is exhausted without an op 7, SHALL return to IDLE with no output.
REQ-026 CORR: SHALL assert res_ready=1 only when the shift register is empty or holds exactly one remaining bit; on res handshake, SHALL load res_data into the shift register and decrement res_cnt.
REQ-027 SHIFT: out_valid=1 and out_value=shreg[RES_W-1] each cycle, for RES_W cycles per result.
REQ-028 A result accepted while its predecessor's last bit is shifting SHALL begin at the next cycle, with no out_valid gap.
REQ-029 If res_valid=0 when a result completes, out_valid SHALL drop to 0 until data arrives; no stale bit SHALL be emitted.
REQ-030 After the last bit of the final result, SHALL drive out_valid=0 the next cycle and return to IDLE.
REQ-031 in_valid2 SHALL be ignored in all states except IDLE and LOAD.
REQ-032 out_value SHALL be 0 whenever out_valid=0.
REQ-033 eng_done outside WAIT SHALL be ignored.

Reset
REQ-034 With rst=1 at an edge: state IDLE; cmd_valid, cmd_op, cmd_size, res_ready, out_valid, and out_value SHALL be 0; queue pointers, res_cnt, and shreg SHALL be 0.
REQ-035 Reset mid-operation SHALL abort immediately with no further commands or bits; the next sequence after reset SHALL run normally.

Verification
REQ-036 Scenario: size 1; actions 0,7; cmd_ready=1; 64 results = index -> 64*20 contiguous out_valid bits, MSB first, matching indices.
REQ-037 Scenario: size 2; actions 1,3,3,3,7 -> cmd_size 2,2,1 for ops 1,3,3; third pool skipped; op 7 issued with cmd_size 0; 16 results.
REQ-038 Scenario: cmd_ready held 0 for 5 cycles -> cmd_valid/op/size stable for 5 cycles; one accept.
REQ-039 Scenario: res_valid deasserted 3 cycles mid-stream -> out_valid 0 for exactly the gap cycles, bit order intact.
REQ-040 Scenario: 10 in_valid2 cycles -> only the first 8 are stored; in_valid2 pulse during SHIFT -> no effect.
REQ-041 Scenario: rst=1 during SHIFT of result 5 -> all outputs 0 next cycle; the following sequence completes correctly.
